// File: rtl/neuron_mac_relu.sv
// Single neuron: sequential multiply-accumulate over N_INPUTS samples, bias add,
// selectable identity/ReLU/leaky-ReLU activation and signed saturation to OUT_W.
module neuron_mac_relu #(
    parameter int DATA_W   = 12,
    parameter int WEIGHT_W = 12,
    parameter int N_INPUTS = 4,
    parameter int OUT_W    = 23,
    localparam int AW      = $clog2(N_INPUTS),
    localparam int ACC_W   = DATA_W + WEIGHT_W + $clog2(N_INPUTS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_we,
    input  logic [AW-1:0]       w_addr,
    input  logic [WEIGHT_W-1:0] w_data,
    input  logic                b_we,
    input  logic [ACC_W-1:0]    b_data,
    input  logic [1:0]          act_mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                busy
);

    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam logic [AW-1:0] LAST_IDX = AW'(N_INPUTS - 1);

    typedef enum logic [1:0] {ST_ACCUM, ST_BIAS, ST_ACT, ST_OUT} state_t;

    state_t                     state_reg, state_next;
    logic [AW-1:0]              idx_reg, idx_next;
    logic signed [ACC_W-1:0]    acc_reg, acc_next;
    logic [OUT_W-1:0]           out_data_reg, out_data_next;
    logic                       out_valid_reg, out_valid_next;
    logic signed [ACC_W-1:0]    bias_reg;
    logic signed [WEIGHT_W-1:0] weight_reg [N_INPUTS];

    logic                       xfer;
    logic                       cfg_ok;
    logic [N_INPUTS-1:0]        w_sel;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    act_val;
    logic [OUT_W-1:0]           sat_val;

    assign in_ready  = (state_reg == ST_ACCUM);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign busy      = !((state_reg == ST_ACCUM) && (idx_reg == '0));
    assign xfer      = in_valid && in_ready;

    // Configuration is only accepted between evaluations, so weights stay frozen mid-run.
    assign cfg_ok = (state_reg == ST_ACCUM) && (idx_reg == '0) && !xfer;

    generate
        for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_wsel
            assign w_sel[gi] = cfg_ok && w_we && (w_addr == AW'(gi));
        end
    endgenerate

    assign prod     = $signed(in_data) * weight_reg[idx_reg];
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    always_comb begin
        act_val = acc_reg;
        case (act_mode)
            2'b00:   act_val = acc_reg;
            2'b10:   act_val = acc_reg[ACC_W-1] ? (acc_reg >>> 3) : acc_reg;
            default: act_val = acc_reg[ACC_W-1] ? '0 : acc_reg;
        endcase
    end

    generate
        if (ACC_W > OUT_W) begin : g_sat
            logic [ACC_W-OUT_W:0] upper;
            assign upper = act_val[ACC_W-1:OUT_W-1];
            always_comb begin
                if ((upper == '0) || (upper == '1))
                    sat_val = act_val[OUT_W-1:0];
                else if (act_val[ACC_W-1])
                    sat_val = {1'b1, {(OUT_W-1){1'b0}}};
                else
                    sat_val = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end else if (ACC_W == OUT_W) begin : g_eq
            assign sat_val = act_val;
        end else begin : g_ext
            assign sat_val = {{(OUT_W-ACC_W){act_val[ACC_W-1]}}, act_val};
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        acc_next       = acc_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        case (state_reg)
            ST_ACCUM: begin
                if (xfer) begin
                    acc_next = acc_reg + prod_ext;
                    if (idx_reg == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = ST_BIAS;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            ST_BIAS: begin
                acc_next   = acc_reg + bias_reg;
                state_next = ST_ACT;
            end
            ST_ACT: begin
                out_data_next  = sat_val;
                out_valid_next = 1'b1;
                state_next     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    acc_next       = '0;
                    state_next     = ST_ACCUM;
                end
            end
            default: state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_ACCUM;
            idx_reg       <= '0;
            acc_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            acc_reg       <= acc_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bias_reg <= '0;
            for (int i = 0; i < N_INPUTS; i++) weight_reg[i] <= '0;
        end else begin
            if (cfg_ok && b_we) bias_reg <= $signed(b_data);
            for (int i = 0; i < N_INPUTS; i++)
                if (w_sel[i]) weight_reg[i] <= $signed(w_data);
        end
    end

endmodule

// File: tb/tb_neuron_mac_relu.sv
// Directed bench for neuron_mac_relu: stimulus pushes expected results to a
// queue, an independent monitor pops and compares on each output handshake.
module tb_neuron_mac_relu;

    localparam int DATA_W   = 12;
    localparam int WEIGHT_W = 12;
    localparam int N_INPUTS = 4;
    localparam int OUT_W    = 23;
    localparam int AW       = 2;
    localparam int ACC_W    = 26;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     w_we = 1'b0;
    logic [AW-1:0]            w_addr = '0;
    logic [WEIGHT_W-1:0]      w_data = '0;
    logic                     b_we = 1'b0;
    logic [ACC_W-1:0]         b_data = '0;
    logic [1:0]               act_mode = 2'b01;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [OUT_W-1:0]  out_data;
    logic                     busy;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_q[$];

    neuron_mac_relu #(
        .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .N_INPUTS(N_INPUTS), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .b_we(b_we), .b_data(b_data),
        .act_mode(act_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_mis++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    // Monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            int got;
            int e;
            got = out_data;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL unexpected_output: got %0d required none", got);
            end else begin
                e = exp_q.pop_front();
                if (got != e) begin
                    n_mis++;
                    $display("FAIL out_data: got %0d required %0d", got, e);
                end else begin
                    $display("out txn: out_data=%0d ok", got);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_out_data", int'(out_data), 0);
    endtask

    task automatic write_w(input int addr, input int val);
        w_we   = 1'b1;
        w_addr = AW'(addr);
        w_data = WEIGHT_W'(val);
        tick();
        w_we = 1'b0;
    endtask

    task automatic write_all_w(input int val);
        for (int i = 0; i < N_INPUTS; i++) write_w(i, val);
    endtask

    task automatic write_b(input int val);
        b_we   = 1'b1;
        b_data = ACC_W'(val);
        tick();
        b_we = 1'b0;
    endtask

    task automatic run_eval(input int s0, input int s1, input int s2, input int s3,
                            input logic [1:0] mode, input int exp_v,
                            input bit gap, input bit stall, input string nm);
        int smp[4];
        smp = '{s0, s1, s2, s3};
        act_mode  = mode;
        out_ready = !stall;
        exp_q.push_back(exp_v);
        $display("eval %s: mode=%0d samples %0d %0d %0d %0d expect %0d",
                 nm, mode, s0, s1, s2, s3, exp_v);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(smp[i]);
            tick();
            in_valid = 1'b0;
            if (gap && i < 3) tick();
        end
        check({nm, "_lat0_valid"}, int'(out_valid), 0);
        check({nm, "_lat0_ready"}, int'(in_ready), 0);
        tick();
        check({nm, "_lat1_valid"}, int'(out_valid), 0);
        tick();
        check({nm, "_lat2_valid"}, int'(out_valid), 1);
        if (stall) begin
            for (int k = 0; k < 5; k++) begin
                check({nm, "_hold_valid"}, int'(out_valid), 1);
                check({nm, "_hold_data"}, int'(out_data), exp_v);
                check({nm, "_hold_ready"}, int'(in_ready), 0);
                check({nm, "_hold_busy"}, int'(busy), 1);
                if (k == 1) begin
                    w_we     = 1'b1;
                    w_addr   = '0;
                    w_data   = WEIGHT_W'(7);
                    in_valid = 1'b1;
                    in_data  = DATA_W'(100);
                end
                tick();
                w_we     = 1'b0;
                in_valid = 1'b0;
            end
            out_ready = 1'b1;
        end
        tick();
        check({nm, "_done_valid"}, int'(out_valid), 0);
        check({nm, "_done_ready"}, int'(in_ready), 1);
        check({nm, "_done_busy"}, int'(busy), 0);
    endtask

    initial begin
        #200000;
        n_mis++;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        do_reset();

        write_all_w(1);
        write_b(0);
        run_eval(10, 10, 10, 23, 2'b01, 53, 1'b0, 1'b0, "relu_b2b");
        run_eval(10, 10, 10, 23, 2'b01, 53, 1'b1, 1'b0, "relu_gap");

        run_eval(-66, 0, 0, -14, 2'b01, 0,   1'b0, 1'b0, "neg_relu");
        run_eval(-66, 0, 0, -14, 2'b10, -10, 1'b0, 1'b0, "neg_leaky");
        run_eval(-66, 0, 0, -14, 2'b00, -80, 1'b0, 1'b0, "neg_ident");
        run_eval(-66, 0, 0, -14, 2'b11, 0,   1'b0, 1'b0, "neg_relu11");
        run_eval(10, 10, 10, 23, 2'b10, 53,  1'b0, 1'b0, "pos_leaky");

        write_all_w(-2048);
        run_eval(-2048, -2048, -2048, -2048, 2'b00, 4194303, 1'b0, 1'b0, "sat_pos");
        write_all_w(2047);
        run_eval(-2048, -2048, -2048, -2048, 2'b00, -4194304, 1'b0, 1'b0, "sat_neg");

        write_all_w(1);
        run_eval(1, 2, 3, 4, 2'b00, 10, 1'b0, 1'b1, "stall");
        run_eval(1, 2, 3, 4, 2'b00, 10, 1'b0, 1'b0, "post_stall");

        // Weight 0 and bias written on the same edge: 5+1+1+1-7.
        w_we   = 1'b1;
        w_addr = '0;
        w_data = WEIGHT_W'(5);
        b_we   = 1'b1;
        b_data = ACC_W'(-7);
        tick();
        w_we = 1'b0;
        b_we = 1'b0;
        run_eval(1, 1, 1, 1, 2'b00, 1, 1'b0, 1'b0, "simul_wb");

        act_mode = 2'b01;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(5);
            tick();
        end
        in_valid = 1'b0;
        check("mid_busy", int'(busy), 1);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_quiet", int'(out_valid), 0);
        end
        run_eval(5, 5, 5, 5, 2'b00, 0, 1'b0, 1'b0, "cleared");
        write_all_w(2);
        write_b(3);
        run_eval(5, 5, 5, 5, 2'b01, 43, 1'b0, 1'b0, "after_rst");

        tick();
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/neuron_mac_relu.md
NEURON_MAC_RELU -- requirements
Module: neuron_mac_relu

Interface
REQ-001 Parameter DATA_W, default 12: signed input sample width.
REQ-002 Parameter WEIGHT_W, default 12: signed weight width.
REQ-003 Parameter N_INPUTS, default 4: samples per neuron evaluation, 2..64.
REQ-004 Parameter OUT_W, default 23: signed output width.
REQ-005 Derived ACC_W = DATA_W+WEIGHT_W+clog2(N_INPUTS), signed accumulator width; AW = clog2(N_INPUTS).
REQ-006 Port clk  in  1: single clock, all state updates on its rising edge.
REQ-007 Port rst  in  1: reset, synchronous and active-high.
REQ-008 Port w_we  in  1: weight write strobe.
REQ-009 Port w_addr  in  AW: weight index.
REQ-010 Port w_data  in  WEIGHT_W: signed weight value.
REQ-011 Port b_we  in  1: bias write strobe.
REQ-012 Port b_data  in  ACC_W: signed bias value.
REQ-013 Port act_mode  in  2: 00 identity, 01 ReLU, 10 leaky ReLU, 11 ReLU.
REQ-014 Port in_valid  in  1: in_data valid.
REQ-015 Port in_ready  out  1: block accepts a sample.
REQ-016 Port in_data  in  DATA_W: signed sample.
REQ-017 Port out_valid  out  1: out_data valid.
REQ-018 Port out_ready  in  1: consumer accepts out_data.
REQ-019 Port out_data  out  OUT_W: signed activated result.
REQ-020 Port busy  out  1: high in every state except ACCUM with idx==0.

Function
REQ-021 FSM states ACCUM, BIAS, ACT, OUT; a sample transfers on a rising edge with in_valid && in_ready.
REQ-022 ACCUM: in_ready=1; each transfer adds in_data*weight[idx] (full-precision signed product, sign-extended) to acc; idx increments.
REQ-023 The transfer at idx==N_INPUTS-1 resets idx to 0 and moves to BIAS.
REQ-024 BIAS: in_ready=0; acc <= acc + bias (ACC_W wrap, no saturation); next state ACT.
REQ-025 ACT: act_mode sampled; identity passes acc; ReLU gives 0 if acc<0 else acc; leaky gives acc>>>3 (arithmetic) if acc<0 else acc.
REQ-026 ACT: activated value saturated to OUT_W signed range [-2^(OUT_W-1), 2^(OUT_W-1)-1], registered into out_data; out_valid=1; next state OUT.
REQ-027 Latency: out_valid rises after the second rising edge following the edge that accepts the last sample.
REQ-028 OUT: out_valid and out_data held stable until out_ready=1; on that edge out_valid=0, acc=0, state ACCUM.
REQ-029 out_ready is ignored while out_valid=0; in_valid is ignored while in_ready=0.
REQ-030 w_we/b_we take effect only in ACCUM with idx==0 and no transfer that edge; otherwise ignored (weights frozen during an evaluation).
REQ-031 Simultaneous w_we and b_we both take effect.
REQ-032 Weights and bias retain values across evaluations; acc starts every evaluation at 0.

Reset
REQ-033 On rst=1 at a rising edge: state=ACCUM, idx=0, acc=0, out_data=0, out_valid=0, in_ready=1 next cycle, busy=0.
REQ-034 Reset clears all weights and bias to 0.
REQ-035 Reset mid-evaluation or while in OUT discards partial results; no out_valid pulse follows.

Verification
REQ-036 Weights all 1, bias 0, mode ReLU, samples 10,10,10,23 back-to-back -> out_data=53, out_valid after 2nd edge past last accept.
REQ-037 Weights 1,1,1,1, bias 0, samples -66,0,0,-14: ReLU -> 0; leaky -> -10; identity -> -80.
REQ-038 Weights all -2048, samples all -2048, bias 0, identity -> out_data saturates to 4194303.
REQ-039 out_ready held 0 for 5 cycles in OUT -> out_data/out_valid stable, in_ready=0; w_we pulse in that window leaves weights unchanged.
REQ-040 rst after 2 of 4 samples, then 4 fresh samples of 5 with weights 2 (rewritten) bias 3, ReLU -> 43.
REQ-041 in_valid toggled every other cycle -> result identical to back-to-back case of REQ-036.
